// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII TX frame sequencer.
package rgmii_pkg;

  // Sequencer states; exported on the top's debug port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SFD   = 3'd2,
    ST_PAY   = 3'd3,
    ST_PAD   = 3'd4,
    ST_FCS   = 3'd5,
    ST_DRAIN = 3'd6,
    ST_IFG   = 3'd7
  } state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

  // phy_tx_mux_ctl encodings: [0] = TX_EN, [1] = TX_EN ^ TX_ER.
  localparam logic [1:0]  CTL_IDLE = 2'b00;
  localparam logic [1:0]  CTL_DATA = 2'b11;
  localparam logic [1:0]  CTL_ERR  = 2'b01;

  // One byte of the reflected IEEE 802.3 CRC-32 (LSB of the byte first).
  function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc,
                                                input logic [7:0]  d);
    logic [31:0] c;
    c = crc ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide Ethernet CRC-32 accumulator; init wins over en.
module eth_crc32_d8
  import rgmii_pkg::*;
(
  input  logic        clk,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic [31:0] crc_q;

  // Registered CRC update: reload on init, fold in d on en, else hold.
  always_ff @(posedge clk) begin
    if (init) begin
      crc_q <= CRC_INIT;
    end else if (en) begin
      crc_q <= crc32_d8_next(crc_q, d);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/rgmii_tx_sched.sv
// Two-source frame sequencer feeding the RGMII TX DDR muxes: round-robin
// grant, preamble/SFD, zero padding, FCS append and inter-frame gap.
//
// Handshake: a source byte is transferred on a rising phy_tx_mux_clk edge
// where src_valid[g] & src_ready[g] are both high. src_ready depends only on
// the registered state, the granted source and reset -- never on src_valid --
// so a source may sample it and hold its byte until it is taken.
module rgmii_tx_sched
  import rgmii_pkg::*;
#(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60,
  parameter int MAX_FRAME = 1514
) (
  input  logic        phy_tx_mux_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  src_valid,
  input  logic [15:0] src_data,
  input  logic [1:0]  src_last,
  output logic [1:0]  src_ready,
  output logic [7:0]  phy_tx_mux_data,
  output logic [1:0]  phy_tx_mux_ctl,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [15:0] err_count,
  output state_e      dbg_state
);

  state_e      state_q, state_d;
  logic        g_q, g_d;          // granted source
  logic        pref_q, pref_d;    // source favoured when both request
  logic [10:0] cnt_q, cnt_d;      // source/pad bytes in the current frame
  logic [7:0]  sub_q, sub_d;      // position inside PRE, FCS or IFG
  logic [7:0]  data_q, data_d;
  logic [1:0]  ctl_q, ctl_d;
  logic [15:0] fc_q, fc_d;
  logic [15:0] ec_q, ec_d;

  logic        crc_init, crc_en;
  logic [7:0]  crc_din;
  logic [31:0] crc;
  logic [31:0] fcs;
  logic [7:0]  fcs_byte;
  logic [10:0] cnt_inc;

  logic        sel_valid, sel_last;
  logic [7:0]  sel_data;

  assign sel_valid = g_q ? src_valid[1] : src_valid[0];
  assign sel_last  = g_q ? src_last[1]  : src_last[0];
  assign sel_data  = g_q ? src_data[15:8] : src_data[7:0];
  assign fcs       = ~crc;
  assign cnt_inc   = cnt_q + 11'd1;

  eth_crc32_d8 u_crc (
    .clk  (phy_tx_mux_clk),
    .init (crc_init),
    .en   (crc_en),
    .d    (crc_din),
    .crc  (crc)
  );

  // FCS goes out least-significant byte first.
  always_comb begin
    fcs_byte = fcs[7:0];
    case (sub_q[1:0])
      2'd0:    fcs_byte = fcs[7:0];
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end

  // Ready is high only for the granted source while bytes are consumed;
  // forced low during reset so nothing is taken while the FSM is cleared.
  always_comb begin
    src_ready = 2'b00;
    if (!reset && (state_q == ST_PAY || state_q == ST_DRAIN)) begin
      src_ready = g_q ? 2'b10 : 2'b01;
    end
  end

  // Next-state logic and the byte/ctl pair to be registered onto the PHY.
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    pref_d   = pref_q;
    cnt_d    = cnt_q;
    sub_d    = sub_q;
    data_d   = 8'h00;
    ctl_d    = CTL_IDLE;
    fc_d     = fc_q;
    ec_d     = ec_q;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    crc_din  = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (enable && (src_valid != 2'b00)) begin
          // Both requesting: take the preferred one; otherwise the only one.
          g_d     = (src_valid == 2'b11) ? pref_q : src_valid[1];
          state_d = ST_PRE;
          sub_d   = 8'd0;
          cnt_d   = 11'd0;
        end
      end

      ST_PRE: begin
        data_d = PREAMBLE_BYTE;
        ctl_d  = CTL_DATA;
        if (sub_q == 8'd6) begin
          state_d = ST_SFD;
          sub_d   = 8'd0;
        end else begin
          sub_d = sub_q + 8'd1;
        end
      end

      ST_SFD: begin
        data_d   = SFD_BYTE;
        ctl_d    = CTL_DATA;
        crc_init = 1'b1;
        state_d  = ST_PAY;
      end

      ST_PAY: begin
        if (cnt_q == 11'(MAX_FRAME) || !sel_valid) begin
          // Oversize or underrun: one error symbol. Any byte taken now is
          // discarded; if it closed the frame there is nothing to drain.
          data_d  = 8'h00;
          ctl_d   = CTL_ERR;
          ec_d    = ec_q + 16'd1;
          sub_d   = 8'd0;
          state_d = (sel_valid && sel_last) ? ST_IFG : ST_DRAIN;
        end else begin
          data_d  = sel_data;
          ctl_d   = CTL_DATA;
          crc_en  = 1'b1;
          crc_din = sel_data;
          cnt_d   = cnt_inc;
          if (sel_last) begin
            sub_d   = 8'd0;
            state_d = (cnt_inc < 11'(MIN_FRAME)) ? ST_PAD : ST_FCS;
          end
        end
      end

      ST_PAD: begin
        data_d  = 8'h00;
        ctl_d   = CTL_DATA;
        crc_en  = 1'b1;
        crc_din = 8'h00;
        cnt_d   = cnt_inc;
        if (cnt_inc == 11'(MIN_FRAME)) begin
          sub_d   = 8'd0;
          state_d = ST_FCS;
        end
      end

      ST_FCS: begin
        data_d = fcs_byte;
        ctl_d  = CTL_DATA;
        if (sub_q == 8'd3) begin
          fc_d    = fc_q + 16'd1;
          sub_d   = 8'd0;
          state_d = ST_IFG;
        end else begin
          sub_d = sub_q + 8'd1;
        end
      end

      ST_DRAIN: begin
        if (sel_valid && sel_last) begin
          sub_d   = 8'd0;
          state_d = ST_IFG;
        end
      end

      ST_IFG: begin
        if (sub_q == 8'(IFG_BYTES - 1)) begin
          // Next contested grant goes to the source not just served.
          pref_d  = ~g_q;
          state_d = ST_IDLE;
        end else begin
          sub_d = sub_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset truncates any frame with no error symbol.
  always_ff @(posedge phy_tx_mux_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      g_q     <= 1'b0;
      pref_q  <= 1'b0;
      cnt_q   <= 11'd0;
      sub_q   <= 8'd0;
      data_q  <= 8'h00;
      ctl_q   <= CTL_IDLE;
      fc_q    <= 16'd0;
      ec_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      pref_q  <= pref_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      data_q  <= data_d;
      ctl_q   <= ctl_d;
      fc_q    <= fc_d;
      ec_q    <= ec_d;
    end
  end

  assign phy_tx_mux_data = data_q;
  assign phy_tx_mux_ctl  = ctl_q;
  assign busy            = (state_q != ST_IDLE);
  assign frame_count     = fc_q;
  assign err_count       = ec_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_rgmii_tx_sched.sv
// Directed bench for rgmii_tx_sched: drives byte-stream frames on both
// sources and checks the PHY byte stream, counters and arbitration order.
module tb_rgmii_tx_sched;
  import rgmii_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic enable;
  always #4 clk = ~clk;

  logic        drv_valid [2];
  logic [7:0]  drv_data  [2];
  logic        drv_last  [2];
  logic [1:0]  src_valid;
  logic [15:0] src_data;
  logic [1:0]  src_last;
  logic [1:0]  src_ready;
  logic [7:0]  tx_data;
  logic [1:0]  tx_ctl;
  logic        busy;
  logic [15:0] frame_count;
  logic [15:0] err_count;
  state_e      dbg_state;

  assign src_valid = {drv_valid[1], drv_valid[0]};
  assign src_data  = {drv_data[1], drv_data[0]};
  assign src_last  = {drv_last[1], drv_last[0]};

  rgmii_tx_sched dut (
    .phy_tx_mux_clk  (clk),
    .reset           (reset),
    .enable          (enable),
    .src_valid       (src_valid),
    .src_data        (src_data),
    .src_last        (src_last),
    .src_ready       (src_ready),
    .phy_tx_mux_data (tx_data),
    .phy_tx_mux_ctl  (tx_ctl),
    .busy            (busy),
    .frame_count     (frame_count),
    .err_count       (err_count),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] byte_q [$];   // every byte seen with ctl = DATA
  int flen_q [$];           // length of each TX_EN window
  int gap_q  [$];           // idle cycles preceding each TX_EN window
  int err_cyc = 0;
  int both_ready = 0;
  int cur_len = 0;
  int gap = 0;
  bit in_frame = 1'b0;
  int acc_cnt [2];
  bit abort = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // MSB-first register fed LSB-first bits: gives the bit-reversed form of
  // the reflected CRC, so a good frame ends on 0xC704DD7B.
  function automatic logic [31:0] crc_msb(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ b[i];
      r  = r << 1;
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (src_ready == 2'b11) both_ready++;
    if (tx_ctl == CTL_DATA) begin
      if (!in_frame) begin
        gap_q.push_back(gap);
        in_frame = 1'b1;
        cur_len  = 0;
      end
      byte_q.push_back(tx_data);
      cur_len++;
      gap = 0;
    end else begin
      if (in_frame) begin
        flen_q.push_back(cur_len);
        in_frame = 1'b0;
      end
      if (tx_ctl == CTL_ERR) begin
        err_cyc++;
        gap = 0;
      end else begin
        gap++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte k of a frame is first+k; valid drops for one cycle before byte drop_at.
  task automatic send_frame(input int src, input int len, input int drop_at,
                            input logic [7:0] first);
    int k;
    int guard;
    bit dropped;
    bit take;
    k = 0;
    guard = 0;
    dropped = 1'b0;
    while (k < len && !abort && guard < 4000) begin
      guard++;
      if (k == drop_at && !dropped) begin
        dropped = 1'b1;
        drv_valid[src] = 1'b0;
        drv_last[src]  = 1'b0;
        tick();
      end else begin
        drv_valid[src] = 1'b1;
        drv_data[src]  = first + 8'(k);
        drv_last[src]  = (k == len - 1);
        @(negedge clk);
        take = drv_valid[src] && src_ready[src];
        tick();
        if (take) begin
          k++;
          acc_cnt[src]++;
        end
      end
    end
    drv_valid[src] = 1'b0;
    drv_last[src]  = 1'b0;
    if (!abort) check($sformatf("drv%0d_done", src), k, len);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < 4000) begin
      @(negedge clk);
      g++;
    end
    check("wait_idle", {31'b0, busy}, 32'd0);
    tick();
  endtask

  task automatic verify_frame(input string tag, input int off, input int plen,
                              input logic [7:0] first);
    int pl;
    int total;
    int bad;
    logic [31:0] c;
    logic [7:0] exp_b;
    pl = (plen < 60) ? 60 : plen;
    total = 8 + pl + 4;
    bad = 0;
    for (int i = 0; i < 7; i++) if (byte_q[off+i] !== 8'h55) bad++;
    if (byte_q[off+7] !== 8'hD5) bad++;
    check({tag, "_pre"}, bad, 0);
    bad = 0;
    for (int i = 0; i < plen; i++) begin
      exp_b = first + 8'(i);
      if (byte_q[off+8+i] !== exp_b) bad++;
    end
    check({tag, "_pay"}, bad, 0);
    bad = 0;
    for (int i = plen; i < pl; i++) if (byte_q[off+8+i] !== 8'h00) bad++;
    check({tag, "_pad"}, bad, 0);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < total; i++) c = crc_msb(c, byte_q[off+i]);
    check({tag, "_crc"}, c, CRC_RESIDUE);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int ob, of, og, e0, bad, g;
    logic [7:0] exp_b;

    reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drv_valid[i] = 1'b0;
      drv_data[i]  = 8'h00;
      drv_last[i]  = 1'b0;
      acc_cnt[i]   = 0;
    end
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_ctl",   tx_ctl, 2'b00);
    check("rst_data",  tx_data, 8'h00);
    check("rst_ready", src_ready, 2'b00);
    check("rst_busy",  busy, 1'b0);
    check("rst_fc",    frame_count, 16'd0);
    check("rst_ec",    err_count, 16'd0);
    tick();

    // enable low: a request must not be granted
    enable = 1'b0;
    drv_valid[0] = 1'b1;
    drv_data[0] = 8'h10;
    repeat (5) tick();
    @(negedge clk);
    check("dis_busy",  busy, 1'b0);
    check("dis_ready", src_ready, 2'b00);
    tick();
    drv_valid[0] = 1'b0;
    enable = 1'b1;
    tick();

    // src0, 46-byte frame: padded to 60, 72-cycle TX_EN window
    ob = byte_q.size(); of = flen_q.size();
    send_frame(0, 46, -1, 8'h10);
    wait_idle();
    check("s0_46_len", flen_q[of], 72);
    verify_frame("s0_46", ob, 46, 8'h10);
    check("s0_46_fc", frame_count, 16'd1);
    check("s0_46_ec", err_count, 16'd0);

    // src1, single byte 0xAB followed by 59 pad bytes
    ob = byte_q.size(); of = flen_q.size();
    send_frame(1, 1, -1, 8'hAB);
    wait_idle();
    check("s1_1_len", flen_q[of], 72);
    verify_frame("s1_1", ob, 1, 8'hAB);
    check("s1_1_fc", frame_count, 16'd2);

    // both sources continuously valid, 64-byte frames: strict alternation
    ob = byte_q.size(); of = flen_q.size(); og = gap_q.size();
    both_ready = 0;
    fork
      begin
        send_frame(0, 64, -1, 8'h10);
        send_frame(0, 64, -1, 8'h10);
      end
      begin
        send_frame(1, 64, -1, 8'h90);
        send_frame(1, 64, -1, 8'h90);
      end
    join
    wait_idle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("arb_len%0d", k), flen_q[of+k], 76);
      verify_frame($sformatf("arb%0d", k), ob + 76*k, 64, (k % 2 == 0) ? 8'h10 : 8'h90);
    end
    // 12 IFG cycles plus the IDLE cycle in which the next grant is made
    for (int k = 1; k < 4; k++) check($sformatf("arb_gap%0d", k), gap_q[og+k], 13);
    check("arb_both_ready", both_ready, 0);
    check("arb_fc", frame_count, 16'd6);

    // src0 underruns before byte 20 of 100; src1 waits behind it
    ob = byte_q.size(); of = flen_q.size(); og = gap_q.size(); e0 = err_cyc;
    fork
      send_frame(0, 100, 20, 8'h10);
      send_frame(1, 1, -1, 8'hAB);
    join
    wait_idle();
    check("ur_len", flen_q[of], 28);
    check("ur_err_cycles", err_cyc - e0, 1);
    check("ur_ec", err_count, 16'd1);
    check("ur_fc", frame_count, 16'd7);
    // error byte, 80 drained bytes, 12 IFG, 1 IDLE before the next preamble
    check("ur_gap", gap_q[og+1], 93);
    check("ur_next_len", flen_q[of+1], 72);
    verify_frame("ur_next", ob + 28, 1, 8'hAB);

    // oversize 1600-byte frame: 1514 bytes go out, then the error symbol
    ob = byte_q.size(); of = flen_q.size(); e0 = err_cyc;
    send_frame(0, 1600, -1, 8'h10);
    wait_idle();
    check("big_len", flen_q[of], 8 + 1514);
    bad = 0;
    for (int i = 0; i < 1514; i++) begin
      exp_b = 8'h10 + 8'(i);
      if (byte_q[ob+8+i] !== exp_b) bad++;
    end
    check("big_pay", bad, 0);
    check("big_err_cycles", err_cyc - e0, 1);
    check("big_ec", err_count, 16'd2);
    check("big_fc", frame_count, 16'd7);

    // reset in the middle of the payload, then a fresh request
    acc_cnt[0] = 0;
    fork
      send_frame(0, 100, -1, 8'h10);
      begin
        g = 0;
        while (acc_cnt[0] < 30 && g < 500) begin
          tick();
          g++;
        end
        check("mrst_reached", {31'b0, acc_cnt[0] >= 30}, 32'd1);
        abort = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mrst_ctl",   tx_ctl, 2'b00);
        check("mrst_data",  tx_data, 8'h00);
        check("mrst_busy",  busy, 1'b0);
        check("mrst_ready", src_ready, 2'b00);
        check("mrst_fc",    frame_count, 16'd0);
        check("mrst_ec",    err_count, 16'd0);
        check("mrst_state", dbg_state, ST_IDLE);
        tick();
        reset = 1'b0;
      end
    join
    abort = 1'b0;
    tick();
    ob = byte_q.size(); of = flen_q.size();
    send_frame(0, 1, -1, 8'h10);
    wait_idle();
    check("post_len", flen_q[of], 72);
    verify_frame("post", ob, 1, 8'h10);
    check("post_fc", frame_count, 16'd1);
    check("post_ec", err_count, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
